mem_port_arbiter: RTL and testbench

- Shares one split-transaction memory bus between the instruction-fetch port and the data-access port of the CPU core.
- The bus uses a req/addr_ok/data_ok handshake.
- The arbiter chooses which requester is presented to the bus and locks that choice until the address is accepted.
- It records the source of each accepted request in an in-order tag FIFO and routes each data_ok/rdata back to the requester that issued it.
- Sits between the core (fetch and memory stages) and the cache/bus bridge.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one split-transaction memory bus (req/addr_ok/data_ok)
// between the instruction-fetch port and the data-access port of the core.
// The selected requester is locked until its address is accepted. Each accepted
// request pushes its source id into an in-order tag FIFO, and the FIFO head
// routes m_data_ok/m_rdata back to the requester that issued the request.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, simultaneous
// requests alternate between the two ports. When it is undefined, the data port
// always wins a tie.
module mem_port_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic             lock_valid_q, lock_valid_d;
    logic             lock_src_q,   lock_src_d;
    logic [PW-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]    count_q,      count_d;
    logic [DEPTH-1:0] tags_q,       tags_d;

    logic sel_s;
    logic sel_req_s;
    logic full_s;
    logic nonempty_s;
    logic accept_s;
    logic pop_s;
    logic head_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_src_q, last_src_d;
`endif

    // Grant selection: a held lock wins. Otherwise a tie goes by the priority policy.
    always_comb begin
        sel_s = 1'b0;
        if (lock_valid_q) begin
            sel_s = lock_src_q;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (inst_req && data_req) begin
            sel_s = ~last_src_q;
        end
`endif
        else if (data_req) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Full is taken from the registered count only, so a same-cycle pop does not free a slot.
    assign full_s     = (count_q == CW'(DEPTH));
    assign nonempty_s = (count_q != {CW{1'b0}});
    assign sel_req_s  = sel_s ? data_req : inst_req;
    assign accept_s   = m_req && m_addr_ok;
    assign pop_s      = m_data_ok && nonempty_s;
    assign head_s     = tags_q[rd_ptr_q];

    // Bus request mux. The fetch path is always a word-sized read.
    always_comb begin
        m_req   = sel_req_s && !full_s;
        m_addr  = inst_addr;
        m_wr    = 1'b0;
        m_size  = 2'd2;
        m_wdata = 32'd0;
        if (sel_s) begin
            m_addr  = data_addr;
            m_wr    = data_wr;
            m_size  = data_size;
            m_wdata = data_wdata;
        end else begin
            m_addr  = inst_addr;
            m_wr    = 1'b0;
            m_size  = 2'd2;
            m_wdata = 32'd0;
        end
    end

    // Handshake and response routing back to the issuing port.
    always_comb begin
        inst_addr_ok = accept_s && !sel_s;
        data_addr_ok = accept_s && sel_s;
        inst_data_ok = pop_s && !head_s;
        data_data_ok = pop_s && head_s;
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
        busy         = nonempty_s;
        err          = m_data_ok && !nonempty_s;
    end

    // Next state for the lock and the tag FIFO.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_src_d   = lock_src_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tags_d       = tags_q;
        if (accept_s) begin
            lock_valid_d     = 1'b0;
            tags_d[wr_ptr_q] = sel_s;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end else if (m_req) begin
            lock_valid_d = 1'b1;
            lock_src_d   = sel_s;
        end else begin
            lock_valid_d = lock_valid_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with a synchronous active-low reset. Tag contents need no reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_valid_q <= 1'b0;
            lock_src_q   <= 1'b0;
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_src_q   <= lock_src_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Tag storage. Entries are only read while the count is nonzero.
    always_ff @(posedge clk) begin
        tags_q <= tags_d;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the last accepted source so the next tie goes to the other port.
    always_comb begin
        if (accept_s) begin
            last_src_d = sel_s;
        end else begin
            last_src_d = last_src_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_src_q <= 1'b0;
        end else begin
            last_src_q <= last_src_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (DEPTH=4). A table of per-cycle vectors
// runs first, then hand-written sequences cover lock, full, mid-run reset and round-robin.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req, data_wr, m_addr_ok, m_data_ok;
    logic [31:0] inst_addr, data_addr, data_wdata, m_rdata;
    logic [1:0]  data_size;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata;
    logic        m_req, m_wr, busy, err;
    logic [1:0]  m_size;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic        ir;  logic [31:0] ia;
        logic        dr;  logic dw; logic [1:0] ds; logic [31:0] da; logic [31:0] dwd;
        logic        aok; logic dok; logic [31:0] rd;
        logic        e_mreq; logic e_mwr; logic [1:0] e_msize;
        logic [31:0] e_maddr; logic [31:0] e_mwdata;
        logic        e_iaok; logic e_daok; logic e_idok; logic e_ddok; logic e_busy; logic e_err;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mkv(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [1:0] ds, input logic [31:0] da, input logic [31:0] dwd,
        input logic aok, input logic dok, input logic [31:0] rd,
        input logic e_mreq, input logic e_mwr, input logic [1:0] e_msize,
        input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
        input logic e_iaok, input logic e_daok, input logic e_idok, input logic e_ddok,
        input logic e_busy, input logic e_err);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.ds = ds; v.da = da; v.dwd = dwd;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_mreq = e_mreq; v.e_mwr = e_mwr; v.e_msize = e_msize; v.e_maddr = e_maddr;
        v.e_mwdata = e_mwdata; v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok;
        v.e_ddok = e_ddok; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [137:0] act, input logic [137:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive all inputs on the falling edge, then settle before sampling.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [1:0] ds, input logic [31:0] da,
                         input logic [31:0] dwd, input logic aok, input logic dok,
                         input logic [31:0] rd);
        @(negedge clk);
        inst_req = ir; inst_addr = ia; data_req = dr; data_wr = dw; data_size = ds;
        data_addr = da; data_wdata = dwd; m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0; data_req = 1'b0; data_wr = 1'b0;
        data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        //            ir ia            dr dw ds    da            dwd           aok dok rd
        //            mreq mwr msize  maddr         mwdata        iaok daok idok ddok busy err
        tv[0]  = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
        tv[1]  = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 1, 32'h12345678,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1);
        tv[2]  = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
        tv[3]  = mkv(1, 32'hBFC00000, 0, 0, 2'd0, 32'h0,        32'h0,        1, 0, 32'h0,
                     1, 0, 2'd2, 32'hBFC00000, 32'h0,        1, 0, 0, 0, 0, 0);
        tv[4]  = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0);
        tv[5]  = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 1, 32'h3C1D0000,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 1, 0, 1, 0);
        tv[6]  = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
        tv[7]  = mkv(1, 32'h00400000, 1, 1, 2'd2, 32'h80001000, 32'hCAFEF00D, 1, 0, 32'h0,
                     1, 1, 2'd2, 32'h80001000, 32'hCAFEF00D, 0, 1, 0, 0, 0, 0);
        tv[8]  = mkv(1, 32'h00400000, 0, 0, 2'd0, 32'h0,        32'h0,        1, 0, 32'h0,
                     1, 0, 2'd2, 32'h00400000, 32'h0,        1, 0, 0, 0, 1, 0);
        tv[9]  = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 1, 32'h11111111,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 1, 1, 0);
        tv[10] = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 1, 32'h22222222,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 1, 0, 1, 0);
        tv[11] = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
        tv[12] = mkv(0, 32'h0,        1, 0, 2'd0, 32'hA0000004, 32'h0,        1, 0, 32'h0,
                     1, 0, 2'd0, 32'hA0000004, 32'h0,        0, 1, 0, 0, 0, 0);
        tv[13] = mkv(1, 32'h00400010, 0, 0, 2'd0, 32'h0,        32'h0,        1, 1, 32'h33333333,
                     1, 0, 2'd2, 32'h00400010, 32'h0,        1, 0, 0, 1, 1, 0);
        tv[14] = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 1, 32'h44444444,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 1, 0, 1, 0);
        tv[15] = mkv(0, 32'h0,        0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0,
                     0, 0, 2'd2, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);

        do_reset();

        // Table: reset state, spurious response, single fetch, contention, push+pop.
        for (int i = 0; i < 16; i++) begin
            drive(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].ds, tv[i].da, tv[i].dwd,
                  tv[i].aok, tv[i].dok, tv[i].rd);
            chk($sformatf("vec%0d", i),
                {m_req, m_wr, m_size, m_addr, m_wdata, inst_addr_ok, data_addr_ok,
                 inst_data_ok, data_data_ok, inst_rdata, data_rdata, busy, err},
                {tv[i].e_mreq, tv[i].e_mwr, tv[i].e_msize, tv[i].e_maddr, tv[i].e_mwdata,
                 tv[i].e_iaok, tv[i].e_daok, tv[i].e_idok, tv[i].e_ddok, tv[i].rd, tv[i].rd,
                 tv[i].e_busy, tv[i].e_err});
        end

        // Lock: fetch stalls for three cycles, and data must not be presented meanwhile.
        drive(1, 32'h00401000, 0, 0, 2'd2, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("lock0_req", m_req, 1'b1);
        chk("lock0_addr", m_addr, 32'h00401000);
        for (int c = 1; c < 4; c++) begin
            drive(1, 32'h00401000, 1, 0, 2'd2, 32'h80002000, 32'h0, (c == 3), 0, 32'h0);
            chk($sformatf("lock%0d_addr", c), m_addr, 32'h00401000);
            chk($sformatf("lock%0d_ok", c), {inst_addr_ok, data_addr_ok}, {(c == 3), 1'b0});
        end
        drive(0, 32'h0, 1, 0, 2'd2, 32'h80002000, 32'h0, 1, 0, 32'h0);
        chk("lock4_addr", m_addr, 32'h80002000);
        chk("lock4_ok", {inst_addr_ok, data_addr_ok, busy}, 3'b011);
        drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h55555555);
        chk("lock_rsp0", {inst_data_ok, data_data_ok}, 2'b10);
        drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h66666666);
        chk("lock_rsp1", {inst_data_ok, data_data_ok}, 2'b01);
        drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("lock_idle_busy", busy, 1'b0);

        // Full: four accepts fill the FIFO, and a pop only frees a grant one cycle later.
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 1, 1, 2'd2, 32'h80003000 + 32'(4 * i), 32'(i), 1, 0, 32'h0);
            chk($sformatf("fill%0d", i), {m_req, data_addr_ok, busy}, {1'b1, 1'b1, (i != 0)});
        end
        drive(0, 32'h0, 1, 1, 2'd2, 32'h80003010, 32'h4, 1, 0, 32'h0);
        chk("full_block", {m_req, data_addr_ok, busy}, 3'b001);
        drive(0, 32'h0, 1, 1, 2'd2, 32'h80003010, 32'h4, 1, 1, 32'h77777777);
        chk("full_pop_same", {m_req, data_addr_ok, data_data_ok, inst_data_ok}, 4'b0010);
        drive(0, 32'h0, 1, 1, 2'd2, 32'h80003010, 32'h4, 1, 0, 32'h0);
        chk("full_pop_next", {m_req, data_addr_ok}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
            chk($sformatf("drain%0d", i), {data_data_ok, inst_data_ok, err}, 3'b100);
        end
        drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("drain_busy", {busy, err}, 2'b00);
        drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
        chk("spur_after_drain", {err, inst_data_ok, data_data_ok, busy}, 4'b1000);

        // Mid-run reset discards the outstanding tag and the inst lock.
        drive(1, 32'h00402000, 0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 32'h0);
        chk("mr_accept", inst_addr_ok, 1'b1);
        drive(1, 32'h00402000, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("mr_locked", {m_req, busy}, 2'b11);
        do_reset();
        drive(1, 32'h00402000, 1, 0, 2'd1, 32'h80004000, 32'h0, 0, 0, 32'h0);
        chk("mr_unlocked", {m_addr, m_size, busy}, {32'h80004000, 2'd1, 1'b0});
        drive(0, 32'h0, 1, 0, 2'd1, 32'h80004000, 32'h0, 1, 0, 32'h0);
        chk("mr_grant", data_addr_ok, 1'b1);
        drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
        chk("mr_rsp", {data_data_ok, inst_data_ok, err}, 3'b100);

`ifdef ARB_ROUND_ROBIN_EN
        // Round-robin: continuous contention alternates grants, starting with data.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h00405000, 1, 0, 2'd2, 32'h80005000, 32'h0, 1, 0, 32'h0);
            chk($sformatf("rr_grant%0d", i), {inst_addr_ok, data_addr_ok},
                {(i % 2 == 1), (i % 2 == 0)});
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 32'h0);
            chk($sformatf("rr_rsp%0d", i), {inst_data_ok, data_data_ok},
                {(i % 2 == 1), (i % 2 == 0)});
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
